// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared state encodings and sizing helper for the hazard controller
package hazard_controller_pkg;

    localparam logic [1:0] HC_RUN      = 2'd0;
    localparam logic [1:0] HC_LOAD_USE = 2'd1;
    localparam logic [1:0] HC_REDIRECT = 2'd2;

    // Redirect countdown width; a single-cycle flush still needs a 1-bit register.
    function automatic int hc_cnt_width(input int flush_cycles);
        return (flush_cycles > 1) ? $clog2(flush_cycles) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - synchronous-clear event counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use/redirect/busy sequencer driving IF/ID/EX stall and flush
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 hc_clk,
    input  logic                 hc_rst,
    input  logic                 hc_i_id_valid,
    input  logic [AWIDTH-1:0]    hc_i_id_addr_rs1,
    input  logic [AWIDTH-1:0]    hc_i_id_addr_rs2,
    input  logic                 hc_i_ex_valid,
    input  logic                 hc_i_ex_is_load,
    input  logic                 hc_i_ex_we_reg,
    input  logic [AWIDTH-1:0]    hc_i_ex_addr_rd,
    input  logic                 hc_i_ex_change_pc,
    input  logic                 hc_i_ex_stall_alu,
    input  logic                 hc_i_mem_stall,
    output logic                 hc_o_stall_if,
    output logic                 hc_o_stall_id,
    output logic                 hc_o_stall_ex,
    output logic                 hc_o_flush_id,
    output logic                 hc_o_flush_ex,
    output logic [1:0]           hc_o_state,
    output logic [CNT_WIDTH-1:0] hc_o_stall_cnt,
    output logic [CNT_WIDTH-1:0] hc_o_flush_cnt
);

    localparam int             CW         = hc_cnt_width(FLUSH_CYCLES);
    localparam logic [CW-1:0]  CNT_RELOAD = CW'(FLUSH_CYCLES - 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          busy, load_use, redirect_acc;

    assign busy     = hc_i_mem_stall | hc_i_ex_stall_alu;
    assign load_use = hc_i_ex_valid & hc_i_ex_is_load & hc_i_ex_we_reg
                    & (hc_i_ex_addr_rd != '0) & hc_i_id_valid
                    & ((hc_i_ex_addr_rd == hc_i_id_addr_rs1) | (hc_i_ex_addr_rd == hc_i_id_addr_rs2));

    always_comb begin
        hc_o_stall_if = 1'b0;
        hc_o_stall_id = 1'b0;
        hc_o_stall_ex = 1'b0;
        hc_o_flush_id = 1'b0;
        hc_o_flush_ex = 1'b0;
        redirect_acc  = 1'b0;
        state_nxt     = state;
        cnt_nxt       = cnt;
        case (state)
            HC_REDIRECT: begin
                hc_o_flush_id = 1'b1;
                if (busy) begin
                    hc_o_stall_if = 1'b1;
                end else if (hc_i_ex_change_pc) begin
                    hc_o_flush_ex = 1'b1;
                    redirect_acc  = 1'b1;
                    cnt_nxt       = CNT_RELOAD;
                    state_nxt     = (FLUSH_CYCLES > 1) ? HC_REDIRECT : HC_RUN;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt <= CW'(1)) state_nxt = HC_RUN;
                end
            end
            HC_LOAD_USE: begin
                // The load has moved to MEM, so the hazard is already resolved here.
                if (busy) begin
                    hc_o_stall_if = 1'b1;
                    hc_o_stall_id = 1'b1;
                    hc_o_stall_ex = 1'b1;
                end else if (hc_i_ex_change_pc) begin
                    hc_o_flush_id = 1'b1;
                    hc_o_flush_ex = 1'b1;
                    redirect_acc  = 1'b1;
                    cnt_nxt       = CNT_RELOAD;
                    state_nxt     = (FLUSH_CYCLES > 1) ? HC_REDIRECT : HC_RUN;
                end else begin
                    state_nxt = HC_RUN;
                end
            end
            default: begin
                state_nxt = HC_RUN;
                if (busy) begin
                    hc_o_stall_if = 1'b1;
                    hc_o_stall_id = 1'b1;
                    hc_o_stall_ex = 1'b1;
                end else if (hc_i_ex_change_pc) begin
                    hc_o_flush_id = 1'b1;
                    hc_o_flush_ex = 1'b1;
                    redirect_acc  = 1'b1;
                    cnt_nxt       = CNT_RELOAD;
                    state_nxt     = (FLUSH_CYCLES > 1) ? HC_REDIRECT : HC_RUN;
                end else if (load_use) begin
                    hc_o_stall_if = 1'b1;
                    hc_o_stall_id = 1'b1;
                    hc_o_flush_ex = 1'b1;
                    state_nxt     = HC_LOAD_USE;
                end
            end
        endcase
        // Reset holds the pipeline empty and suppresses any accounting.
        if (!hc_rst) begin
            hc_o_stall_if = 1'b0;
            hc_o_stall_id = 1'b0;
            hc_o_stall_ex = 1'b0;
            hc_o_flush_id = 1'b1;
            hc_o_flush_ex = 1'b1;
            redirect_acc  = 1'b0;
        end
    end

    assign hc_o_state = hc_rst ? state : HC_RUN;

    always_ff @(posedge hc_clk) begin
        if (!hc_rst) begin
            state <= HC_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (hc_clk),
        .clear (!hc_rst),
        .inc   (hc_o_stall_if),
        .count (hc_o_stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (hc_clk),
        .clear (!hc_rst),
        .inc   (redirect_acc),
        .count (hc_o_flush_cnt)
    );

endmodule
